// File: rtl/pixel_pkg.sv
// Shared definitions for the HPS-to-image-RAM pixel loader: FSM states,
// default frame geometry and the bit positions of the status nibbles.
package pixel_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam int DEF_H_RES  = 320;
    localparam int DEF_V_RES  = 240;
    localparam int DEF_ADDR_W = 18;

    // status_in bit positions (HPS -> fabric)
    localparam int IN_REQ   = 0;
    localparam int IN_START = 1;

    // status_out bit positions (fabric -> HPS)
    localparam int ST_ACK_BIT  = 0;
    localparam int ST_BUSY_BIT = 1;
    localparam int ST_DONE_BIT = 2;
    localparam int ST_ERR_BIT  = 3;

endpackage

// File: rtl/pixel_loader.sv
// Takes one RGB888 pixel per HPS req/ack toggle handshake and writes it to the
// image RAM in raster order, tracking row/col and end-of-frame.
//
//   state   | meaning
//   IDLE    | waiting for a req toggle or a frame start
//   WRITE   | single-cycle RAM write of the captured pixel
//   ACK     | ack toggled, row/col advance on exit
module pixel_loader
    import pixel_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [23:0]       pixel_data,
    input  logic [3:0]        status_in,
    output logic [3:0]        status_out,
    output logic [15:0]       row_out,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    output logic [31:0]       ram_writedata,
    output logic [3:0]        ram_byteenable
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [ADDR_W-1:0] H_RES_A  = ADDR_W'(H_RES);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req_q;
    logic             r_start_q;
    logic             r_start_pend;
    logic [23:0]      r_pixel;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_ack;
    logic             r_done;
    logic             r_err;

    logic w_req;
    logic w_start_edge;
    logic w_start_any;
    logic w_capture;
    logic w_reject;
    logic w_clear;
    logic w_advance;
    logic w_ack_flip;
    logic w_strobe;
    logic w_busy;
    logic w_unused;

    assign w_req        = status_in[IN_REQ] ^ r_req_q;
    assign w_start_edge = status_in[IN_START] & ~r_start_q;
    assign w_start_any  = w_start_edge | r_start_pend;
    assign w_unused     = &{1'b0, status_in[3:2]};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A frame start in IDLE wins over a simultaneous request; the request
    // stays visible because the req copy has not advanced.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_reject    = 1'b0;
        w_clear     = 1'b0;
        w_advance   = 1'b0;
        w_ack_flip  = 1'b0;
        w_strobe    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_any) begin
                    w_clear = 1'b1;
                end else if (w_req) begin
                    if (r_done) begin
                        w_reject   = 1'b1;
                        w_ack_flip = 1'b1;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_strobe    = 1'b1;
                w_busy      = 1'b1;
                w_ack_flip  = 1'b1;
                w_state_nxt = S_ACK;
            end
            S_ACK: begin
                w_busy      = 1'b1;
                w_advance   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_req_q      <= status_in[IN_REQ];
            r_start_q    <= status_in[IN_START];
            r_start_pend <= 1'b0;
            r_pixel      <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_ack        <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_start_q <= status_in[IN_START];

            if (w_clear) begin
                r_start_pend <= 1'b0;
            end else if (w_start_edge && (r_state != S_IDLE)) begin
                r_start_pend <= 1'b1;
            end

            if (w_capture || w_reject) begin
                r_req_q <= status_in[IN_REQ];
            end
            if (w_capture) begin
                r_pixel <= pixel_data;
            end
            if (w_ack_flip) begin
                r_ack <= ~r_ack;
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end

            // Last pixel of the frame leaves row/col parked on the final position.
            if (w_clear) begin
                r_col  <= '0;
                r_row  <= '0;
                r_done <= 1'b0;
                r_err  <= 1'b0;
            end else if (w_advance) begin
                if (r_col == COL_LAST) begin
                    if (r_row == ROW_LAST) begin
                        r_done <= 1'b1;
                    end else begin
                        r_col <= '0;
                        r_row <= r_row + ROW_W'(1);
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
        end
    end

    always_comb begin
        status_out              = '0;
        status_out[ST_ACK_BIT]  = r_ack;
        status_out[ST_BUSY_BIT] = w_busy;
        status_out[ST_DONE_BIT] = r_done;
        status_out[ST_ERR_BIT]  = r_err;
    end

    assign row_out        = 16'(r_row);
    assign ram_address    = (ADDR_W'(r_row) * H_RES_A) + ADDR_W'(r_col);
    assign ram_chipselect = w_strobe;
    assign ram_write      = w_strobe;
    assign ram_clken      = w_strobe;
    assign ram_writedata  = {8'h00, r_pixel};
    assign ram_byteenable = 4'hF;

endmodule

// File: tb/tb_pixel_loader.sv
// Scoreboard bench for pixel_loader: the driver predicts each RAM write from a
// raster pixel count, and a negedge monitor checks every write the DUT makes.
module tb_pixel_loader;

    localparam int H     = 320;
    localparam int V     = 4;
    localparam int AW    = 18;
    localparam int FRAME = H * V;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic [23:0]   pixel_data;
    logic [3:0]    status_in;
    logic [3:0]    status_out;
    logic [15:0]   row_out;
    logic [AW-1:0] ram_address;
    logic          ram_chipselect;
    logic          ram_write;
    logic          ram_clken;
    logic [31:0]   ram_writedata;
    logic [3:0]    ram_byteenable;

    pixel_loader #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .pixel_data     (pixel_data),
        .status_in      (status_in),
        .status_out     (status_out),
        .row_out        (row_out),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_clken      (ram_clken),
        .ram_writedata  (ram_writedata),
        .ram_byteenable (ram_byteenable)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   k;        // pixels written in the current frame
    logic m_ack;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_row();
        return (k >= FRAME) ? 32'(V - 1) : 32'(k / H);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    always @(negedge clk_clk) begin
        if (!reset_reset && (ram_chipselect || ram_write || ram_clken)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         ram_address, ram_writedata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_strobes", {29'd0, ram_chipselect, ram_write, ram_clken}, 32'd7);
                check("wr_addr", 32'(ram_address), 32'(e.addr));
                check("wr_data", ram_writedata, e.data);
                check("wr_be", 32'(ram_byteenable), 32'hF);
            end
        end
    end

    task automatic send_pixel(input logic [23:0] pix);
        pixel_data   = pix;
        status_in[0] = ~status_in[0];
        exp_q.push_back(wr_t'{addr: AW'(k), data: {8'h00, pix}});
        tick(1);
        check("busy_write", 32'(status_out[1]), 32'd1);
        check("ack_hold", 32'(status_out[0]), 32'(m_ack));
        tick(1);
        m_ack = ~m_ack;
        check("ack_toggle", 32'(status_out[0]), 32'(m_ack));
        tick(1);
        k++;
        check("busy_idle", 32'(status_out[1]), 32'd0);
        check("row", 32'(row_out), exp_row());
        check("done", 32'(status_out[2]), 32'(k == FRAME));
    endtask

    task automatic run_to(input int target);
        while (k < target) begin
            send_pixel(24'($urandom));
            tick($urandom_range(0, 2));
        end
    endtask

    task automatic send_pair(input logic [23:0] p1, input logic [23:0] p2);
        int   toggles;
        logic last;
        toggles      = 0;
        last         = status_out[0];
        pixel_data   = p1;
        status_in[0] = ~status_in[0];
        exp_q.push_back(wr_t'{addr: AW'(k), data: {8'h00, p1}});
        tick(1);
        pixel_data   = p2;
        status_in[0] = ~status_in[0];
        exp_q.push_back(wr_t'{addr: AW'(k + 1), data: {8'h00, p2}});
        for (int c = 0; c < 20 && !(toggles == 2 && status_out[1] == 1'b0); c++) begin
            tick(1);
            if (status_out[0] != last) begin
                toggles++;
                last = status_out[0];
            end
        end
        check("pair_acks", 32'(toggles), 32'd2);
        k += 2;
        check("pair_row", 32'(row_out), exp_row());
    endtask

    initial begin
        reset_reset = 1'b1;
        status_in   = 4'b0000;
        pixel_data  = 24'h0;
        k           = 0;
        m_ack       = 1'b0;
        tick(3);
        check("rst_status", 32'(status_out), 32'd0);
        check("rst_row", 32'(row_out), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_wdata", ram_writedata, 32'd0);
        check("rst_strobes", {29'd0, ram_chipselect, ram_write, ram_clken}, 32'd0);
        reset_reset = 1'b0;
        tick(2);
        check("post_rst_status", 32'(status_out), 32'd0);

        // first pixel, fixed colour, lands at address 0
        send_pixel(24'hFF0000);
        tick(1);

        run_to(H);
        check("row_after_320", 32'(row_out), 32'd1);
        send_pixel(24'h00FF00);
        send_pair(24'($urandom), 24'($urandom));

        run_to(FRAME);
        check("frame_done", 32'(status_out[2]), 32'd1);
        check("frame_row", 32'(row_out), 32'(V - 1));

        // request after the frame is full: no write, error flag, ack next cycle
        pixel_data   = 24'($urandom);
        status_in[0] = ~status_in[0];
        tick(1);
        m_ack = ~m_ack;
        check("err_ack", 32'(status_out[0]), 32'(m_ack));
        check("err_flag", 32'(status_out[3]), 32'd1);
        check("err_busy", 32'(status_out[1]), 32'd0);
        tick(3);
        check("err_ack_stable", 32'(status_out[0]), 32'(m_ack));
        check("err_idle", 32'(status_out[1]), 32'd0);

        // frame start from IDLE clears position and flags
        status_in[1] = 1'b1;
        tick(1);
        k = 0;
        check("fs_row", 32'(row_out), 32'd0);
        check("fs_done", 32'(status_out[2]), 32'd0);
        check("fs_err", 32'(status_out[3]), 32'd0);
        status_in[1] = 1'b0;
        tick(1);
        send_pixel(24'h123456);

        // frame start raised during WRITE is deferred until the pixel completes
        run_to(H + 10);
        pixel_data   = 24'($urandom);
        status_in[0] = ~status_in[0];
        exp_q.push_back(wr_t'{addr: AW'(k), data: {8'h00, pixel_data}});
        tick(1);
        status_in[1] = 1'b1;
        tick(1);
        m_ack = ~m_ack;
        check("pend_ack", 32'(status_out[0]), 32'(m_ack));
        tick(1);
        k++;
        check("pend_row_kept", 32'(row_out), exp_row());
        tick(1);
        k = 0;
        check("pend_row_clr", 32'(row_out), 32'd0);
        check("pend_flags", 32'(status_out[3:1]), 32'd0);
        status_in[1] = 1'b0;
        tick(1);
        send_pixel(24'($urandom));

        // reset during WRITE aborts the pixel with no ack
        pixel_data   = 24'($urandom);
        status_in[0] = ~status_in[0];
        tick(1);
        reset_reset = 1'b1;
        tick(1);
        check("midrst_strobes", {29'd0, ram_chipselect, ram_write, ram_clken}, 32'd0);
        check("midrst_status", 32'(status_out), 32'd0);
        reset_reset = 1'b0;
        k     = 0;
        m_ack = 1'b0;
        tick(3);
        check("midrst_quiet", 32'(status_out), 32'd0);
        check("midrst_row", 32'(row_out), 32'd0);
        send_pixel(24'($urandom));
        tick(3);

        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
